// File: rtl/nand_logic_unit_seq.sv
// Sequential N-bit two-operand logic unit: eight NAND-built Boolean functions
// evaluated BITS_PER_CYCLE bits per clock, LSB chunk first, with a ones count.
module nand_logic_unit_seq #(
  parameter  int unsigned WIDTH          = 8,
  parameter  int unsigned BITS_PER_CYCLE = 1,
  localparam int unsigned CW             = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [CW-1:0]    ones
);

  localparam int unsigned BPC = BITS_PER_CYCLE;
  localparam int unsigned N   = WIDTH / BPC;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;

  logic             last;
  int unsigned      shamt;
  logic [BPC-1:0]   ca, cb, na, nb, ab, t_or, t_xor, res;
  logic [CW-1:0]    pop;
  logic [WIDTH-1:0] s_nxt;
  logic [CW-1:0]    ones_nxt;

  function automatic logic [BPC-1:0] nd(input logic [BPC-1:0] x, input logic [BPC-1:0] y);
    return ~(x & y);
  endfunction

  // Chunk evaluation: every function is composed from the nd() primitive.
  always_comb begin
    shamt = 32'(idx) * BPC;
    last  = (idx == IW'(N - 1));
    ca    = BPC'(a_q >> shamt);
    cb    = BPC'(b_q >> shamt);
    na    = nd(ca, ca);
    nb    = nd(cb, cb);
    ab    = nd(ca, cb);
    t_or  = nd(na, nb);
    t_xor = nd(nd(ca, ab), nd(cb, ab));
    case (op_q)
      3'b000:  res = nd(ab, ab);
      3'b001:  res = t_or;
      3'b010:  res = ab;
      3'b011:  res = nd(t_or, t_or);
      3'b100:  res = t_xor;
      3'b101:  res = nd(t_xor, t_xor);
      3'b110:  res = nd(na, cb);
      default: res = nd(ca, nb);
    endcase
    pop = '0;
    for (int i = 0; i < int'(BPC); i++) begin
      pop = pop + CW'(res[i]);
    end
    // Unprocessed bits of s are still zero, so OR-ing in the chunk is exact.
    s_nxt    = s | (WIDTH'(res) << shamt);
    ones_nxt = ones + pop;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == FINISH);
    end
  end

  // Operand capture and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      idx  <= '0;
      s    <= '0;
      ones <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            idx  <= '0;
            s    <= '0;
            ones <= '0;
          end
        end
        RUN: begin
          s    <= s_nxt;
          ones <= ones_nxt;
          idx  <= last ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_logic_unit_seq.sv
// Bench for nand_logic_unit_seq: four instances (8b x BPC 1/4/2, 1b) share stimulus
// and are checked against a word-level Boolean model, vector table and hand sequences.
module tb_nand_logic_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [2:0] op;
  logic [7:0] a, b;

  always #5 clk = ~clk;

  logic [7:0] s_o    [4];
  logic [3:0] ones_o [4];
  logic       busy_o [4];
  logic       done_o [4];
  logic       s1, ones1, busy1, done1;
  logic [7:0] s8a, s8b, s8c;
  logic [3:0] o8a, o8b, o8c;
  logic       b8a, b8b, b8c, d8a, d8b, d8c;

  nand_logic_unit_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(b8a), .done(d8a), .s(s8a), .ones(o8a));
  nand_logic_unit_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(b8b), .done(d8b), .s(s8b), .ones(o8b));
  nand_logic_unit_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_b2 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(b8c), .done(d8c), .s(s8c), .ones(o8c));
  nand_logic_unit_seq #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[0]), .b(b[0]),
    .busy(busy1), .done(done1), .s(s1), .ones(ones1));

  assign s_o[0] = s8a;  assign ones_o[0] = o8a;  assign busy_o[0] = b8a;  assign done_o[0] = d8a;
  assign s_o[1] = s8b;  assign ones_o[1] = o8b;  assign busy_o[1] = b8b;  assign done_o[1] = d8b;
  assign s_o[2] = s8c;  assign ones_o[2] = o8c;  assign busy_o[2] = b8c;  assign done_o[2] = d8c;
  assign s_o[3] = {7'd0, s1}; assign ones_o[3] = {3'd0, ones1};
  assign busy_o[3] = busy1;   assign done_o[3] = done1;

  int n_cmp = 0;
  int n_bad = 0;
  int nch [4] = '{8, 2, 4, 1};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level reference: the Boolean functions applied to whole operands.
  function automatic logic [7:0] model(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    case (f)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return x | ~y;
      default: return ~x | y;
    endcase
  endfunction

  // One operation on all instances; optionally disturbs inputs/start mid-run.
  task automatic run_op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y, input bit disturb);
    logic [7:0] e, ei;
    int dcnt [4], bcnt [4], dat [4];
    int ninst;
    e = model(f, x, y);
    ninst = disturb ? 3 : 4;
    for (int i = 0; i < 4; i++) begin dcnt[i] = 0; bcnt[i] = 0; dat[i] = -1; end
    @(negedge clk);
    op = f; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      for (int i = 0; i < ninst; i++) begin
        ei = (i == 3) ? {7'd0, e[0]} : e;
        if (busy_o[i]) bcnt[i]++;
        if (done_o[i]) begin
          dcnt[i]++;
          dat[i] = k;
          chk($sformatf("s_at_done[%0d]", i), int'(s_o[i]), int'(ei));
          chk($sformatf("ones_at_done[%0d]", i), int'(ones_o[i]), $countones(ei));
        end
        chk($sformatf("busy_done_overlap[%0d]", i), int'(busy_o[i] & done_o[i]), 0);
      end
      if (disturb && k == 2) begin a = 8'h00; b = 8'h00; start = 1'b1; end
      if (disturb && k == 3) start = 1'b0;
    end
    for (int i = 0; i < ninst; i++) begin
      ei = (i == 3) ? {7'd0, e[0]} : e;
      chk($sformatf("done_count[%0d]", i), dcnt[i], 1);
      chk($sformatf("done_cycle[%0d]", i), dat[i], nch[i]);
      chk($sformatf("busy_cycles[%0d]", i), bcnt[i], nch[i]);
      chk($sformatf("s_hold[%0d]", i), int'(s_o[i]), int'(ei));
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, es;
    logic [3:0] eo;
    logic       es1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int prev, cnt;
    vecs[0] = '{3'd6, 8'hA5, 8'h0F, 8'hF5, 4'd6, 1'b1};
    vecs[1] = '{3'd4, 8'h3C, 8'hC3, 8'hFF, 4'd8, 1'b1};
    vecs[2] = '{3'd2, 8'hFF, 8'hFF, 8'h00, 4'd0, 1'b0};
    vecs[3] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 4'd2, 1'b0};
    vecs[4] = '{3'd1, 8'h01, 8'h00, 8'h01, 4'd1, 1'b1};
    vecs[5] = '{3'd6, 8'h00, 8'h00, 8'hFF, 4'd8, 1'b1};
    vecs[6] = '{3'd6, 8'h00, 8'h01, 8'hFE, 4'd7, 1'b0};
    vecs[7] = '{3'd6, 8'h01, 8'h00, 8'hFF, 4'd8, 1'b1};
    vecs[8] = '{3'd6, 8'h01, 8'h01, 8'hFF, 4'd8, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    #12;
    chk("reset_s", int'(s_o[0]), 0);
    chk("reset_ones", int'(ones_o[0]), 0);
    chk("reset_busy", int'(busy_o[0]), 0);
    chk("reset_done", int'(done_o[0]), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, 1'b0);
      chk($sformatf("vec%0d_s", v), int'(s_o[0]), int'(vecs[v].es));
      chk($sformatf("vec%0d_ones", v), int'(ones_o[0]), int'(vecs[v].eo));
      chk($sformatf("vec%0d_s_bpc4", v), int'(s_o[1]), int'(vecs[v].es));
      chk($sformatf("vec%0d_s_w1", v), int'(s_o[3]), int'(vecs[v].es1));
    end

    // Inputs changed and start re-pulsed mid-run must not disturb the op.
    run_op(3'd0, 8'hF0, 8'h3C, 1'b1);
    chk("capture_s", int'(s_o[0]), 8'h30);
    chk("capture_ones", int'(ones_o[0]), 2);
    repeat (4) @(posedge clk);

    // Asynchronous reset in the middle of a run, then a fresh operation.
    @(negedge clk);
    op = 3'd0; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("partial_s", int'(s_o[0]), 8'h0F);
    chk("partial_ones", int'(ones_o[0]), 4);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_busy", int'(busy_o[0]), 0);
    chk("midreset_done", int'(done_o[0]), 0);
    chk("midreset_s", int'(s_o[0]), 0);
    chk("midreset_ones", int'(ones_o[0]), 0);
    chk("midreset_s_bpc2", int'(s_o[2]), 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(3'd1, 8'h01, 8'h00, 1'b0);
    chk("post_reset_s", int'(s_o[0]), 8'h01);
    chk("post_reset_ones", int'(ones_o[0]), 1);

    for (int r = 0; r < 30; r++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
    end

    // start held high: BPC=2 instance completes every 6 cycles.
    @(negedge clk);
    op = 3'd7; a = 8'h5A; b = 8'h33; start = 1'b1;
    prev = -1; cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done_o[2]) begin
        if (prev >= 0) chk("b2b_spacing", k - prev, 6);
        prev = k;
        cnt++;
      end
      for (int i = 0; i < 4; i++)
        chk($sformatf("b2b_overlap[%0d]", i), int'(busy_o[i] & done_o[i]), 0);
    end
    start = 1'b0;
    chk("b2b_done_count", cnt, 5);
    chk("b2b_s", int'(s_o[2]), int'(model(3'd7, 8'h5A, 8'h33)));
    repeat (15) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
